// File: rtl/data_mem_lsu.sv
// Multi-cycle load/store unit between the core and a variable-latency data memory.
// Packs sb/sh/sw into word address, byte enables and lane-replicated write data,
// and sign/zero-extends lb/lh/lw/lbu/lhu/lwu read data. stall_o freezes the core
// until the access retires with a one-cycle rsp_valid_o pulse.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise the offending low address bits are forced to zero.
// Only DATA_WIDTH = 32 is supported; memory depth is 2**DATA_MEM_ADDR_WIDTH words.
module data_mem_lsu #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned DATA_MEM_ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  // Core side
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_we_i,
  input  logic [2:0]                     req_funct3_i,
  input  logic [31:0]                    req_addr_i,
  input  logic [DATA_WIDTH-1:0]          req_wdata_i,
  output logic                           rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           rsp_fault_o,
  output logic                           stall_o,
  // Memory side
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]                     mem_be_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                         state_q, state_d;
  logic                           we_q, we_d;
  logic [2:0]                     f3_q, f3_d;
  logic [1:0]                     off_q, off_d;
  logic [DATA_MEM_ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [3:0]                     be_q, be_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic                           fault_q, fault_d;

  logic                           acc_illegal, acc_fault;
  logic [1:0]                     acc_off;
  logic [3:0]                     acc_be;
  logic [DATA_WIDTH-1:0]          acc_wdata;
  logic [DATA_WIDTH-1:0]          ld_data;
  logic [7:0]                     ld_byte;
  logic [15:0]                    ld_half;
  logic                           is_resp;
  logic                           unused_addr;

  // Address bits above the word index are dropped so accesses wrap on the memory depth.
  assign unused_addr = ^req_addr_i[31:DATA_MEM_ADDR_WIDTH+2];

  // Stores only support b/h/w; loads reject 011 and 111.
  assign acc_illegal = req_we_i ? (req_funct3_i > 3'b010)
                                : ((req_funct3_i == 3'b011) || (req_funct3_i == 3'b111));

`ifdef LSU_MISALIGN_TRAP_EN
  logic acc_misalign;
  assign acc_misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign acc_fault    = acc_illegal || acc_misalign;
`else
  assign acc_fault    = acc_illegal;
`endif

  // Effective lane offset, byte enables and replicated write data for the incoming request.
  always_comb begin
    acc_off   = req_addr_i[1:0];
    acc_be    = 4'b1111;
    acc_wdata = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        acc_be    = 4'b0001 << acc_off;
        acc_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        acc_off   = {req_addr_i[1], 1'b0};
        acc_be    = 4'b0011 << acc_off;
        acc_wdata = {2{req_wdata_i[15:0]}};
      end
      default: acc_off = 2'b00;
    endcase
  end

  // Lane select and extension of returning read data.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = f3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state logic; rvalid is only honoured in StWait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i)  state_d = acc_fault ? StResp : StReq;
      StReq:   if (mem_gnt_i)    state_d = we_q ? StResp : StWait;
      StWait:  if (mem_rvalid_i) state_d = StResp;
      StResp:                    state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  // FSM outputs; response data is zeroed outside the response pulse.
  always_comb begin
    is_resp     = (state_q == StResp);
    req_ready_o = (state_q == StIdle);
    mem_req_o   = (state_q == StReq);
    mem_we_o    = (state_q == StReq) && we_q;
    rsp_valid_o = is_resp;
    rsp_fault_o = is_resp && fault_q;
    rsp_rdata_o = is_resp ? rdata_q : '0;
    stall_o     = ((state_q != StIdle) || req_valid_i) && !is_resp;
  end

  assign mem_addr_o  = maddr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  // Request capture on accept and load-data capture on rvalid.
  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    maddr_d = maddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    if ((state_q == StIdle) && req_valid_i) begin
      we_d    = req_we_i;
      f3_d    = req_funct3_i;
      off_d   = acc_off;
      maddr_d = req_addr_i[DATA_MEM_ADDR_WIDTH+1:2];
      be_d    = acc_be;
      wdata_d = acc_wdata;
      rdata_d = '0;
      fault_d = acc_fault;
    end else if ((state_q == StWait) && mem_rvalid_i) begin
      rdata_d = ld_data;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      maddr_q <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      maddr_q <= maddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule
